// File: rtl/tetris_pkg.sv
// Shared types and default board dimensions for the piece movement logic.
package tetris_pkg;

    localparam int ROWS_DEF = 20;
    localparam int COLS_DEF = 10;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_HOLD  = 2'd3
    } move_dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cell_step.sv
// Combinational evaluation of one piece cell: candidate position after the
// move, bounds check and occupancy lookup against the settled board.
module cell_step
    import tetris_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic [1:ROWS][1:COLS] board,
    input  logic [3:0]            x,
    input  logic [4:0]            y,
    input  move_dir_t             dir,
    output logic [4:0]            cand_x,
    output logic [5:0]            cand_y,
    output logic                  blocked
);

    logic in_bounds;
    logic occupied;

    // Candidate coordinates use one extra bit so edge cells never wrap back
    // into range; the board is only consulted for in-bounds candidates.
    always_comb begin
        cand_x   = {1'b0, x};
        cand_y   = {1'b0, y};
        occupied = 1'b0;
        case (dir)
            DIR_LEFT:  cand_x = {1'b0, x} - 5'd1;
            DIR_RIGHT: cand_x = {1'b0, x} + 5'd1;
            DIR_DOWN:  cand_y = {1'b0, y} + 6'd1;
            default:   ;
        endcase
        in_bounds = (cand_x >= 5'd1) && (cand_x <= 5'(COLS)) &&
                    (cand_y >= 6'd1) && (cand_y <= 6'(ROWS));
        for (int r = 1; r <= ROWS; r++) begin
            for (int c = 1; c <= COLS; c++) begin
                if (in_bounds && (cand_y == 6'(r)) && (cand_x == 5'(c))) begin
                    occupied = board[r][c];
                end
            end
        end
        // A zero input coordinate marks an invalid cell, whatever the move.
        blocked = (x == 4'd0) || (y == 5'd0) || !in_bounds || occupied;
    end

endmodule

// File: rtl/piece_move_check.sv
// Checks whether the active piece may move one step LEFT/RIGHT/DOWN (or HOLD)
// by evaluating its four cells sequentially through one shared cell_step.
module piece_move_check
    import tetris_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:ROWS][1:COLS] board,
    input  logic [3:0]            ixpos1,
    input  logic [3:0]            ixpos2,
    input  logic [3:0]            ixpos3,
    input  logic [3:0]            ixpos4,
    input  logic [4:0]            iypos1,
    input  logic [4:0]            iypos2,
    input  logic [4:0]            iypos3,
    input  logic [4:0]            iypos4,
    input  logic                  move_req,
    input  logic [1:0]            move_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  move_ok,
    output logic                  lock_req,
    output logic [3:0]            oxpos1,
    output logic [3:0]            oxpos2,
    output logic [3:0]            oxpos3,
    output logic [3:0]            oxpos4,
    output logic [4:0]            oypos1,
    output logic [4:0]            oypos2,
    output logic [4:0]            oypos3,
    output logic [4:0]            oypos4
);

    state_t     state_reg, state_next;
    move_dir_t  dir_reg;
    logic [1:0] idx_reg;
    logic       last_reg;
    logic       blocked_reg;
    logic       move_ok_reg;
    logic       lock_req_reg;

    logic [3:0] in_x [4];
    logic [4:0] in_y [4];
    logic [3:0] x_reg [4];
    logic [4:0] y_reg [4];
    logic [3:0] cx_reg [4];
    logic [4:0] cy_reg [4];
    logic [3:0] ox_reg [4];
    logic [4:0] oy_reg [4];

    logic [4:0] step_cx;
    logic [5:0] step_cy;
    logic       step_blocked;

    assign in_x[0] = ixpos1;
    assign in_x[1] = ixpos2;
    assign in_x[2] = ixpos3;
    assign in_x[3] = ixpos4;
    assign in_y[0] = iypos1;
    assign in_y[1] = iypos2;
    assign in_y[2] = iypos3;
    assign in_y[3] = iypos4;

    assign oxpos1 = ox_reg[0];
    assign oxpos2 = ox_reg[1];
    assign oxpos3 = ox_reg[2];
    assign oxpos4 = ox_reg[3];
    assign oypos1 = oy_reg[0];
    assign oypos2 = oy_reg[1];
    assign oypos3 = oy_reg[2];
    assign oypos4 = oy_reg[3];

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign move_ok  = move_ok_reg;
    assign lock_req = lock_req_reg;

    cell_step #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_cell_step (
        .board   (board),
        .x       (x_reg[idx_reg]),
        .y       (y_reg[idx_reg]),
        .dir     (dir_reg),
        .cand_x  (step_cx),
        .cand_y  (step_cy),
        .blocked (step_blocked)
    );

    // Next-state logic: four evaluation cycles then one commit cycle in CHECK.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (move_req) state_next = CHECK;
            CHECK:   if (last_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, capture, per-cell evaluation and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            dir_reg      <= DIR_HOLD;
            idx_reg      <= 2'd0;
            last_reg     <= 1'b0;
            blocked_reg  <= 1'b0;
            move_ok_reg  <= 1'b0;
            lock_req_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_reg[i]  <= '0;
                y_reg[i]  <= '0;
                cx_reg[i] <= '0;
                cy_reg[i] <= '0;
                ox_reg[i] <= '0;
                oy_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (move_req) begin
                        for (int i = 0; i < 4; i++) begin
                            x_reg[i] <= in_x[i];
                            y_reg[i] <= in_y[i];
                        end
                        dir_reg     <= move_dir_t'(move_dir);
                        blocked_reg <= 1'b0;
                        idx_reg     <= 2'd0;
                        last_reg    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!last_reg) begin
                        // Board is sampled here, so later board changes only
                        // influence cells that have not been evaluated yet.
                        blocked_reg     <= blocked_reg | step_blocked;
                        cx_reg[idx_reg] <= step_cx[3:0];
                        cy_reg[idx_reg] <= step_cy[4:0];
                        idx_reg         <= idx_reg + 2'd1;
                        last_reg        <= (idx_reg == 2'd3);
                    end else begin
                        move_ok_reg  <= !blocked_reg;
                        lock_req_reg <= blocked_reg && (dir_reg == DIR_DOWN);
                        for (int i = 0; i < 4; i++) begin
                            ox_reg[i] <= blocked_reg ? x_reg[i] : cx_reg[i];
                            oy_reg[i] <= blocked_reg ? y_reg[i] : cy_reg[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_move_check.sv
// Self-checking bench: directed cases plus randomized requests against a
// rule-level reference model of the piece move check.
module tb_piece_move_check;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [1:ROWS][1:COLS] board = '0;
    logic [3:0]            ixpos1 = '0, ixpos2 = '0, ixpos3 = '0, ixpos4 = '0;
    logic [4:0]            iypos1 = '0, iypos2 = '0, iypos3 = '0, iypos4 = '0;
    logic                  move_req = 1'b0;
    logic [1:0]            move_dir = '0;
    logic                  busy, done, move_ok, lock_req;
    logic [3:0]            oxpos1, oxpos2, oxpos3, oxpos4;
    logic [4:0]            oypos1, oypos2, oypos3, oypos4;

    int compared = 0;
    int mismatched = 0;

    // Reference state: occupancy grid with a margin, piece cells, expectations.
    bit occ [0:ROWS+1][0:COLS+1];
    int px [4];
    int py [4];
    int ex [4];
    int ey [4];
    bit e_ok, e_lock;

    piece_move_check #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset_n(reset_n), .board(board),
        .ixpos1(ixpos1), .ixpos2(ixpos2), .ixpos3(ixpos3), .ixpos4(ixpos4),
        .iypos1(iypos1), .iypos2(iypos2), .iypos3(iypos3), .iypos4(iypos4),
        .move_req(move_req), .move_dir(move_dir),
        .busy(busy), .done(done), .move_ok(move_ok), .lock_req(lock_req),
        .oxpos1(oxpos1), .oxpos2(oxpos2), .oxpos3(oxpos3), .oxpos4(oxpos4),
        .oypos1(oypos1), .oypos2(oypos2), .oypos3(oypos3), .oypos4(oypos4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_occ();
        for (int r = 0; r <= ROWS + 1; r++)
            for (int c = 0; c <= COLS + 1; c++)
                occ[r][c] = 1'b0;
    endtask

    task automatic pack_board();
        for (int r = 1; r <= ROWS; r++)
            for (int c = 1; c <= COLS; c++)
                board[r[4:0]][c[3:0]] = occ[r][c];
    endtask

    task automatic set_piece(input int x0, y0, x1, y1, x2, y2, x3, y3);
        px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1;
        px[2] = x2; py[2] = y2; px[3] = x3; py[3] = y3;
    endtask

    // Game rule: shift every cell by the direction's offset; the move is
    // illegal if any cell is invalid, leaves the board, or lands on a block.
    task automatic model(input int dir);
        int dx, dy, cx, cy;
        bit blk;
        dx = (dir == 0) ? -1 : (dir == 1) ? 1 : 0;
        dy = (dir == 2) ? 1 : 0;
        blk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cx = px[i] + dx;
            cy = py[i] + dy;
            if (px[i] == 0 || py[i] == 0) blk = 1'b1;
            else if (cx < 1 || cx > COLS || cy < 1 || cy > ROWS) blk = 1'b1;
            else if (occ[cy][cx]) blk = 1'b1;
            ex[i] = blk ? 0 : cx;
            ey[i] = blk ? 0 : cy;
        end
        e_ok = !blk;
        e_lock = blk && (dir == 2);
        for (int i = 0; i < 4; i++) begin
            ex[i] = blk ? px[i] : px[i] + dx;
            ey[i] = blk ? py[i] : py[i] + dy;
        end
    endtask

    // One complete request; optionally pulses move_req again mid-CHECK.
    task automatic do_req(input string name, input int dir, input bit extra_pulse);
        int k;
        bit seen;
        model(dir);
        ixpos1 = px[0][3:0]; ixpos2 = px[1][3:0]; ixpos3 = px[2][3:0]; ixpos4 = px[3][3:0];
        iypos1 = py[0][4:0]; iypos2 = py[1][4:0]; iypos3 = py[2][4:0]; iypos4 = py[3][4:0];
        move_dir = dir[1:0];
        move_req = 1'b1;
        @(posedge clk); #1;
        move_req = 1'b0;
        // Captured values must not depend on the inputs after capture.
        ixpos1 = 4'($urandom); ixpos2 = 4'($urandom); ixpos3 = 4'($urandom); ixpos4 = 4'($urandom);
        iypos1 = 5'($urandom); iypos2 = 5'($urandom); iypos3 = 5'($urandom); iypos4 = 5'($urandom);
        move_dir = 2'($urandom);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        seen = 1'b0;
        while (k < 10 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (extra_pulse) move_req = (k == 2);
            seen = done;
        end
        move_req = 1'b0;
        chk({name, "_latency"}, 32'(k), 32'd5);
        chk({name, "_move_ok"}, 32'(move_ok), 32'(e_ok));
        chk({name, "_lock_req"}, 32'(lock_req), 32'(e_lock));
        chk({name, "_x"}, {16'd0, oxpos1, oxpos2, oxpos3, oxpos4},
            {16'd0, ex[0][3:0], ex[1][3:0], ex[2][3:0], ex[3][3:0]});
        chk({name, "_y"}, {12'd0, oypos1, oypos2, oypos3, oypos4},
            {12'd0, ey[0][4:0], ey[1][4:0], ey[2][4:0], ey[3][4:0]});
        $display("req %s dir=%0d move_ok=%0d lock_req=%0d latency=%0d", name, dir, move_ok, lock_req, k);
        @(posedge clk); #1;
        chk({name, "_done_low"}, {30'd0, done, busy}, 32'd0);
        chk({name, "_hold"}, {23'd0, move_ok, oxpos1, oypos4}, {23'd0, e_ok, ex[0][3:0], ey[3][4:0]});
        if (extra_pulse) begin
            seen = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(posedge clk); #1;
                if (done) seen = 1'b1;
            end
            chk({name, "_single_done"}, 32'(seen), 32'd0);
        end
    endtask

    initial begin
        clear_occ();
        pack_board();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {28'd0, busy, done, move_ok, lock_req}, 32'd0);
        chk("rst_x", {16'd0, oxpos1, oxpos2, oxpos3, oxpos4}, 32'd0);
        chk("rst_y", {12'd0, oypos1, oypos2, oypos3, oypos4}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        set_piece(5, 1, 6, 1, 5, 2, 6, 2);
        do_req("down_empty", 2, 1'b0);

        set_piece(1, 5, 1, 6, 1, 7, 2, 7);
        do_req("left_wall", 0, 1'b0);

        set_piece(5, 19, 5, 20, 6, 20, 4, 20);
        do_req("down_floor", 2, 1'b0);

        occ[3][5] = 1'b1;
        pack_board();
        set_piece(5, 1, 6, 1, 5, 2, 6, 2);
        do_req("down_stack", 2, 1'b0);

        clear_occ();
        occ[2][7] = 1'b1;
        pack_board();
        do_req("right_block", 1, 1'b1);

        // Abort a request with reset on its third edge.
        clear_occ();
        pack_board();
        set_piece(3, 4, 4, 4, 5, 4, 6, 4);
        ixpos1 = 4'd3; ixpos2 = 4'd4; ixpos3 = 4'd5; ixpos4 = 4'd6;
        iypos1 = 5'd4; iypos2 = 5'd4; iypos3 = 5'd4; iypos4 = 5'd4;
        move_dir = 2'd1;
        move_req = 1'b1;
        @(posedge clk); #1;
        move_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ctrl", {28'd0, busy, done, move_ok, lock_req}, 32'd0);
        chk("abort_pos", {7'd0, oxpos1, oxpos4, oypos1, oypos2, oypos4}, 32'd0);
        reset_n = 1'b1;
        begin
            bit seen_done;
            seen_done = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(posedge clk); #1;
                if (done) seen_done = 1'b1;
            end
            chk("abort_no_done", 32'(seen_done), 32'd0);
        end
        do_req("after_abort", 1, 1'b0);

        set_piece(0, 3, 4, 3, 5, 3, 6, 3);
        do_req("hold_zero", 3, 1'b0);
        set_piece(4, 3, 5, 3, 6, 3, 5, 4);
        do_req("hold_free", 3, 1'b0);

        set_piece(10, 10, 10, 11, 9, 11, 9, 12);
        do_req("right_wall", 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            clear_occ();
            for (int r = 1; r <= ROWS; r++)
                for (int c = 1; c <= COLS; c++)
                    occ[r][c] = ($urandom_range(0, 7) == 0);
            pack_board();
            for (int i = 0; i < 4; i++) begin
                px[i] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, COLS));
                py[i] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, ROWS));
            end
            do_req("rand", int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
